e_mdu: RTL and testbench

- Multi-cycle multiply/divide unit with its sequencing controller, placed in the E stage beside the ALU.
- Owns the HI/LO architectural registers and runs mult/multu/div/divu over a fixed cycle count.
- Serves mfhi/mflo/mthi/mtlo.
- Exports busy so the hazard unit can stall any MDU-class instruction in D while an operation is outstanding.

---
 rtl/e_mdu_pkg.sv | 32 +++
 rtl/e_mdu.sv | 146 ++++++++++++++
 tb/tb_e_mdu.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/e_mdu_pkg.sv
// Shared opcode, state and payload definitions for the E-stage multiply/divide unit.
package e_mdu_pkg;

  localparam int unsigned XLEN = 32;

  // 4-bit MDU operation codes carried on mdu_op.
  typedef enum logic [3:0] {
    MDU_NONE  = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MFHI  = 4'd5,
    MDU_MFLO  = 4'd6,
    MDU_MTHI  = 4'd7,
    MDU_MTLO  = 4'd8
  } mdu_op_e;

  // Sequencer states.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } mdu_state_e;

  // Pending HI/LO result held while an operation sequences.
  typedef struct packed {
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
  } hilo_t;

endpackage

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: owns HI/LO, sequences mult/div over a fixed
// cycle count and exports busy for the hazard unit.
module e_mdu
  import e_mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [3:0]  mdu_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        req,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] rd_data
);

  localparam int unsigned MAX_CYC = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  hilo_t            tmp_q, tmp_d;
  logic             dz_q, dz_d;
  logic             done_c;
  logic             accept_c;

  logic [63:0] prod_s, prod_u;
  logic [31:0] a_mag, b_mag, sdiv_b, q_mag, r_mag, q_s, r_s;
  logic [31:0] udiv_b, q_u, r_u;

  assign accept_c = start & ~req & (state_q == S_IDLE);

  // Products: sign-extended operands for mult, zero-extended for multu.
  assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
  assign prod_u = {32'd0, A} * {32'd0, B};

  // Signed divide on magnitudes; quotient truncates toward zero, remainder follows dividend.
  // A zero divisor is replaced by 1 only to keep the datapath defined; the result is discarded.
  assign a_mag  = A[31] ? -A : A;
  assign b_mag  = B[31] ? -B : B;
  assign sdiv_b = (b_mag == 32'd0) ? 32'd1 : b_mag;
  assign q_mag  = a_mag / sdiv_b;
  assign r_mag  = a_mag % sdiv_b;
  assign q_s    = (A[31] ^ B[31]) ? -q_mag : q_mag;
  assign r_s    = A[31] ? -r_mag : r_mag;
  assign udiv_b = (B == 32'd0) ? 32'd1 : B;
  assign q_u    = A / udiv_b;
  assign r_u    = A % udiv_b;

  // Next-state, counter and pending-result selection.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tmp_d   = tmp_q;
    dz_d    = dz_q;
    done_c  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          case (mdu_op)
            MDU_MULT: begin
              state_d = S_MUL;
              cnt_d   = CNT_W'(MULT_CYCLES);
              tmp_d   = prod_s;
              dz_d    = 1'b0;
            end
            MDU_MULTU: begin
              state_d = S_MUL;
              cnt_d   = CNT_W'(MULT_CYCLES);
              tmp_d   = prod_u;
              dz_d    = 1'b0;
            end
            MDU_DIV: begin
              state_d  = S_DIV;
              cnt_d    = CNT_W'(DIV_CYCLES);
              tmp_d.hi = r_s;
              tmp_d.lo = q_s;
              dz_d     = (B == 32'd0);
            end
            MDU_DIVU: begin
              state_d  = S_DIV;
              cnt_d    = CNT_W'(DIV_CYCLES);
              tmp_d.hi = r_u;
              tmp_d.lo = q_u;
              dz_d     = (B == 32'd0);
            end
            default: ;
          endcase
        end
      end
      S_MUL, S_DIV: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_IDLE;
          done_c  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Sequencer state, counter, pending result and registered busy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      tmp_q   <= '0;
      dz_q    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tmp_q   <= tmp_d;
      dz_q    <= dz_d;
      busy    <= (state_d != S_IDLE);
    end
  end

  // HI/LO: committed at op completion (unless divide by zero) or by mthi/mtlo.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      HI <= '0;
      LO <= '0;
    end else if (done_c && !dz_q) begin
      HI <= tmp_q.hi;
      LO <= tmp_q.lo;
    end else if (accept_c && (mdu_op == MDU_MTHI)) begin
      HI <= A;
    end else if (accept_c && (mdu_op == MDU_MTLO)) begin
      LO <= A;
    end
  end

  // Read port for mfhi/mflo; the hazard unit stalls reads while busy.
  always_comb begin
    rd_data = '0;
    if (mdu_op == MDU_MFHI)      rd_data = HI;
    else if (mdu_op == MDU_MFLO) rd_data = LO;
  end

endmodule

// File: tb/tb_e_mdu.sv
// Directed bench for e_mdu with an arithmetic reference model of HI/LO/busy.
module tb_e_mdu;
  import e_mdu_pkg::*;

  localparam int unsigned MULT_N = 5;
  localparam int unsigned DIV_N  = 10;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [3:0]  mdu_op;
  logic [31:0] A, B;
  logic        req;
  logic        busy;
  logic [31:0] HI, LO, rd_data;

  int checks = 0;
  int errors = 0;
  bit armed  = 1'b0;
  int n;

  e_mdu #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .mdu_op(mdu_op),
    .A(A), .B(B), .req(req), .busy(busy), .HI(HI), .LO(LO), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: architectural HI/LO plus the number of busy cycles left.
  logic [31:0] m_hi, m_lo, m_rhi, m_rlo;
  int          m_left;
  bit          m_wr;
  longint      sa, sb, sp;
  longint unsigned ua, ub, up;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_hi = 0; m_lo = 0; m_left = 0; m_wr = 0;
    end else if (m_left > 0) begin
      if (m_left == 1 && m_wr) begin
        m_hi = m_rhi;
        m_lo = m_rlo;
      end
      m_left--;
    end else if (start && !req) begin
      sa = longint'($signed(A));
      sb = longint'($signed(B));
      ua = A;
      ub = B;
      case (mdu_op)
        MDU_MULT: begin
          sp = sa * sb;
          m_rhi = sp[63:32]; m_rlo = sp[31:0]; m_wr = 1; m_left = MULT_N;
        end
        MDU_MULTU: begin
          up = ua * ub;
          m_rhi = up[63:32]; m_rlo = up[31:0]; m_wr = 1; m_left = MULT_N;
        end
        MDU_DIV: begin
          m_wr = (B != 0);
          if (B != 0) begin
            sp = sa / sb; m_rlo = sp[31:0];
            sp = sa % sb; m_rhi = sp[31:0];
          end
          m_left = DIV_N;
        end
        MDU_DIVU: begin
          m_wr = (B != 0);
          if (B != 0) begin
            up = ua / ub; m_rlo = up[31:0];
            up = ua % ub; m_rhi = up[31:0];
          end
          m_left = DIV_N;
        end
        MDU_MTHI: m_hi = A;
        MDU_MTLO: m_lo = A;
        default: ;
      endcase
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (armed) begin
      chk("busy", {31'd0, busy}, {31'd0, (m_left > 0)});
      chk("HI", HI, m_hi);
      chk("LO", LO, m_lo);
      if (mdu_op == MDU_MFHI) chk("rd_hi", rd_data, m_hi);
      if (mdu_op == MDU_MFLO) chk("rd_lo", rd_data, m_lo);
    end
  end

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic r);
    start = 1'b1; mdu_op = op; A = a; B = b; req = r;
    @(posedge clk); #1;
    start = 1'b0; req = 1'b0; mdu_op = MDU_NONE;
  endtask

  // Counts remaining busy cycles, bounded.
  task automatic wait_idle(output int cnt);
    cnt = 0;
    while (busy && cnt < 200) begin
      cnt++;
      @(posedge clk); #1;
    end
    chk("idle_reached", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; req = 1'b0; mdu_op = MDU_NONE; A = '0; B = '0;
    #12;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_hi", HI, 32'd0);
    chk("rst_lo", LO, 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    armed   = 1'b1;
    @(posedge clk); #1;

    // Signed and unsigned multiply.
    issue(MDU_MULT, 32'hFFFF_FFFF, 32'd2, 1'b0);
    wait_idle(n);
    chk("mult_cycles", 32'(n), 32'd5);
    chk("mult_hi", HI, 32'hFFFF_FFFF);
    chk("mult_lo", LO, 32'hFFFF_FFFE);

    issue(MDU_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0);
    wait_idle(n);
    chk("multu_cycles", 32'(n), 32'd5);
    chk("multu_hi", HI, 32'h0000_0001);
    chk("multu_lo", LO, 32'hFFFF_FFFE);

    // Signed divide, including the overflow corner.
    issue(MDU_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
    wait_idle(n);
    chk("div_cycles", 32'(n), 32'd10);
    chk("div_lo", LO, 32'hFFFF_FFFD);
    chk("div_hi", HI, 32'hFFFF_FFFF);

    issue(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    wait_idle(n);
    chk("divov_lo", LO, 32'h8000_0000);
    chk("divov_hi", HI, 32'h0000_0000);

    // mthi, then divide by zero leaves HI/LO alone.
    issue(MDU_MTHI, 32'h1234_5678, 32'd0, 1'b0);
    chk("mthi_busy", {31'd0, busy}, 32'd0);
    chk("mthi_hi", HI, 32'h1234_5678);
    issue(MDU_DIVU, 32'd7, 32'd0, 1'b0);
    wait_idle(n);
    chk("dz_cycles", 32'(n), 32'd10);
    chk("dz_hi", HI, 32'h1234_5678);
    chk("dz_lo", LO, 32'h8000_0000);
    start = 1'b1; mdu_op = MDU_MFLO; #1;
    chk("mflo", rd_data, 32'h8000_0000);
    mdu_op = MDU_MFHI; #1;
    chk("mfhi", rd_data, 32'h1234_5678);
    start = 1'b0; mdu_op = MDU_NONE;
    @(posedge clk); #1;

    // mtlo, then a flushed start does nothing.
    issue(MDU_MTLO, 32'h0000_00AA, 32'd0, 1'b0);
    chk("mtlo_lo", LO, 32'h0000_00AA);
    issue(MDU_MULT, 32'd3, 32'd4, 1'b1);
    chk("req_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    chk("req_hi", HI, 32'h1234_5678);
    chk("req_lo", LO, 32'h0000_00AA);

    // req during an in-flight op does not disturb it.
    issue(MDU_MULT, 32'd3, 32'd4, 1'b0);
    @(posedge clk); #1;
    req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    wait_idle(n);
    chk("reqmid_cycles", 32'(n + 2), 32'd5);
    chk("reqmid_lo", LO, 32'd12);
    chk("reqmid_hi", HI, 32'd0);

    // Start while busy is ignored.
    issue(MDU_DIV, 32'd100, 32'd7, 1'b0);
    issue(MDU_MULT, 32'd5, 32'd5, 1'b0);
    wait_idle(n);
    chk("busystart_cycles", 32'(n + 1), 32'd10);
    chk("busystart_lo", LO, 32'd14);
    chk("busystart_hi", HI, 32'd2);

    // Unknown opcode is ignored.
    issue(4'hF, 32'd1, 32'd2, 1'b0);
    chk("unk_busy", {31'd0, busy}, 32'd0);

    // Asynchronous reset in the third busy cycle of a divide.
    issue(MDU_DIV, 32'd200, 32'd7, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2 reset_n = 1'b0;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_hi", HI, 32'd0);
    chk("arst_lo", LO, 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    start = 1'b1; mdu_op = MDU_MFLO; #1;
    chk("post_rst_mflo", rd_data, 32'd0);
    start = 1'b0; mdu_op = MDU_NONE;
    repeat (12) @(posedge clk);
    #1;
    chk("post_rst_hi", HI, 32'd0);
    chk("post_rst_lo", LO, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
